rho_rotate_func: RTL

//  Keccak rho stage. Sits directly downstream of the column-parity/theta stage and consumes its
//  25-bit slice output. Loads a full 1600-bit state as 64 slices of 25 bits, then rotates each

---
 rtl/rho_pkg.sv | 26 ++
 rtl/rho_rotate_func_if.sv | 29 ++
 rtl/rho_slice_buf.sv | 28 ++
 rtl/rho_rotate_func.sv | 83 ++++++++
 4 files changed

// File: rtl/rho_pkg.sv
// rtl/rho_pkg.sv - shared constants, rho offsets and FSM state type for the rho stage
package rho_pkg;

    localparam int SLICES = 64;
    localparam int LANES  = 25;
    localparam int CNT_W  = 6;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLICES - 1);

    // Left-rotation amount of lane i, where slice bit i = lane (x + 5*y)
    localparam logic [CNT_W-1:0] RHO_OFF [LANES] = '{
        6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
        6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
        6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
        6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
        6'd18, 6'd2,  6'd61, 6'd56, 6'd14
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } rho_state_t;

endpackage

// File: rtl/rho_rotate_func_if.sv
// rtl/rho_rotate_func_if.sv - slice read/write bus between the rho stage and its neighbours
interface rho_rotate_func_if;

    logic                      start;
    logic [rho_pkg::CNT_W-1:0] cnt_value;
    logic [rho_pkg::LANES-1:0] line_in;
    logic                      write_enable;
    logic [rho_pkg::LANES-1:0] write_value;
    logic                      done;

    modport master (
        input  start,
        input  line_in,
        output cnt_value,
        output write_enable,
        output write_value,
        output done
    );

    modport slave (
        output start,
        output line_in,
        input  cnt_value,
        input  write_enable,
        input  write_value,
        input  done
    );

endinterface

// File: rtl/rho_slice_buf.sv
// rtl/rho_slice_buf.sv - 64x25 slice register file with one write port and per-lane rotated reads
module rho_slice_buf
    import rho_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [CNT_W-1:0] wr_addr,
    input  logic [LANES-1:0] wr_data,
    input  logic [CNT_W-1:0] rd_base,
    output logic [LANES-1:0] rd_data
);

    logic [LANES-1:0] mem [SLICES];

    // Contents deliberately survive reset; every run reloads all slices before reading.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [CNT_W-1:0] rd_addr;
        assign rd_addr    = rd_base - RHO_OFF[i];
        assign rd_data[i] = mem[rd_addr][i];
    end

endmodule

// File: rtl/rho_rotate_func.sv
// rtl/rho_rotate_func.sv - Keccak rho stage: load 64 slices, write back 64 lane-rotated slices
module rho_rotate_func
    import rho_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    rho_rotate_func_if.master  bus
);

    rho_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             phase, phase_n;
    logic             start_q;
    logic             buf_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            phase   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            phase   <= phase_n;
            start_q <= bus.start;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        phase_n = phase;
        buf_we  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start && !start_q) begin
                    state_n = LOAD;
                    cnt_n   = '0;
                end
            end
            LOAD: begin
                buf_we = 1'b1;
                cnt_n  = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    state_n = WRITE;
                    phase_n = 1'b0;
                end
            end
            WRITE: begin
                // Two cycles per slice so each write gets its own write_enable rising edge
                if (!phase) begin
                    phase_n = 1'b1;
                end else begin
                    phase_n = 1'b0;
                    cnt_n   = cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    rho_slice_buf u_buf (
        .clk     (clk),
        .we      (buf_we),
        .wr_addr (cnt),
        .wr_data (bus.line_in),
        .rd_base (cnt),
        .rd_data (bus.write_value)
    );

    assign bus.cnt_value    = cnt;
    assign bus.write_enable = (state == WRITE) && !phase;
    assign bus.done         = (state == DONE);

endmodule
